// File: rtl/rx_source_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rx_source_ctrl
//  Description : Drives the SIM_EN select of the receive-path source mux.
//                Switches between the simulated link source and the live DTC
//                transceiver on a comma boundary (or after a timeout), then
//                flushes and re-qualifies alignment before declaring link-up.
//                Monitors lock loss and symbol errors while the link is up.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_source_ctrl #(
    parameter logic [15:0] Comma     = 16'hBC3C,
    parameter logic [1:0]  KChar     = 2'b11,
    parameter int unsigned HOLD_CYC  = 4,
    parameter int unsigned ALIGN_CYC = 16,
    parameter int unsigned COMMA_TO  = 1024
) (
    input  logic        RX_CLK,
    input  logic        RX_RSTN,
    input  logic        SIM_REQ,
    input  logic        ERR_CLR,
    input  logic [15:0] SIM_DATA,
    input  logic [15:0] DTC_DATA,
    input  logic [1:0]  SIM_K_CHAR,
    input  logic [1:0]  DTC_K_CHAR,
    input  logic [1:0]  SIM_CODE_ERR_N,
    input  logic [1:0]  DTC_CODE_ERR_N,
    input  logic [1:0]  SIM_INVALID,
    input  logic [1:0]  DTC_INVALID,
    input  logic        SIM_ALIGNED,
    input  logic        DTC_ALIGNED,
    input  logic        SIM_RX_VALID,
    input  logic        DTC_RX_VALID,
    output logic        SIM_EN,
    output logic        LINK_UP,
    output logic        SWITCHING,
    output logic        LOCK_LOST,
    output logic [7:0]  LOSS_CNT,
    output logic [15:0] ERR_CNT,
    output logic [1:0]  STATE
);

    localparam logic [1:0] c_ST_ALIGN_WAIT = 2'd0;
    localparam logic [1:0] c_ST_RUN        = 2'd1;
    localparam logic [1:0] c_ST_COMMA_WAIT = 2'd2;
    localparam logic [1:0] c_ST_HOLD       = 2'd3;

    // Terminal values of the shared wait/hold/align counter
    localparam logic [15:0] c_HOLD_LAST  = 16'(HOLD_CYC - 1);
    localparam logic [15:0] c_ALIGN_LAST = 16'(ALIGN_CYC - 1);
    localparam logic [15:0] c_TO_LAST    = 16'(COMMA_TO - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        sim_en_q, sim_en_d;
    logic        link_up_q, link_up_d;
    logic        switching_q, switching_d;
    logic        lock_lost_q, lock_lost_d;
    logic [7:0]  loss_cnt_q, loss_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic        w_good;
    logic        w_comma;
    logic        w_err;
    logic        w_req_diff;
    logic        w_loss_inc;
    logic        w_err_inc;

    // Qualify the currently selected source: good / comma / error
    always_comb begin
        if (sim_en_q) begin
            w_good  = SIM_ALIGNED & SIM_RX_VALID;
            w_comma = (SIM_DATA == Comma) && (SIM_K_CHAR == KChar);
            w_err   = (SIM_CODE_ERR_N != 2'b11) || (SIM_INVALID != 2'b00);
        end else begin
            w_good  = DTC_ALIGNED & DTC_RX_VALID;
            w_comma = (DTC_DATA == Comma) && (DTC_K_CHAR == KChar);
            w_err   = (DTC_CODE_ERR_N != 2'b11) || (DTC_INVALID != 2'b00);
        end
        w_req_diff = SIM_REQ ^ sim_en_q;
    end

    // Next-state, select toggle and lock-loss detection
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        sim_en_d    = sim_en_q;
        lock_lost_d = 1'b0;
        w_loss_inc  = 1'b0;
        case (state_q)
            c_ST_ALIGN_WAIT: begin
                // Link is down, so no boundary is needed before switching
                if (w_req_diff) begin
                    state_d  = c_ST_HOLD;
                    sim_en_d = ~sim_en_q;
                end else if (!w_good) begin
                    cnt_d = '0;
                end else if (cnt_q == c_ALIGN_LAST) begin
                    state_d = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                cnt_d = '0;
                // Lock loss takes priority over a pending source request
                if (!w_good) begin
                    state_d     = c_ST_ALIGN_WAIT;
                    lock_lost_d = 1'b1;
                    w_loss_inc  = 1'b1;
                end else if (w_req_diff) begin
                    state_d = c_ST_COMMA_WAIT;
                end
            end
            c_ST_COMMA_WAIT: begin
                if (!w_good) begin
                    state_d     = c_ST_HOLD;
                    sim_en_d    = ~sim_en_q;
                    lock_lost_d = 1'b1;
                    w_loss_inc  = 1'b1;
                end else if (!w_req_diff) begin
                    state_d = c_ST_RUN;
                end else if (w_comma || (cnt_q == c_TO_LAST)) begin
                    state_d  = c_ST_HOLD;
                    sim_en_d = ~sim_en_q;
                end
            end
            c_ST_HOLD: begin
                // Request and source inputs are deliberately ignored here
                if (cnt_q == c_HOLD_LAST) begin
                    state_d = c_ST_ALIGN_WAIT;
                end
            end
            default: begin
                state_d = c_ST_ALIGN_WAIT;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
        link_up_d   = (state_d == c_ST_RUN) || (state_d == c_ST_COMMA_WAIT);
        switching_d = (state_d == c_ST_COMMA_WAIT) || (state_d == c_ST_HOLD);
    end

    // Saturating event counters; clear wins over a same-cycle increment
    always_comb begin
        w_err_inc  = (state_q == c_ST_RUN) && w_err;
        loss_cnt_d = loss_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (ERR_CLR) begin
            loss_cnt_d = '0;
            err_cnt_d  = '0;
        end else begin
            if (w_loss_inc && (loss_cnt_q != 8'hFF)) begin
                loss_cnt_d = loss_cnt_q + 8'd1;
            end
            if (w_err_inc && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge RX_CLK or negedge RX_RSTN) begin
        if (!RX_RSTN) begin
            state_q     <= c_ST_ALIGN_WAIT;
            cnt_q       <= '0;
            sim_en_q    <= 1'b0;
            link_up_q   <= 1'b0;
            switching_q <= 1'b0;
            lock_lost_q <= 1'b0;
            loss_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sim_en_q    <= sim_en_d;
            link_up_q   <= link_up_d;
            switching_q <= switching_d;
            lock_lost_q <= lock_lost_d;
            loss_cnt_q  <= loss_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign SIM_EN    = sim_en_q;
    assign LINK_UP   = link_up_q;
    assign SWITCHING = switching_q;
    assign LOCK_LOST = lock_lost_q;
    assign LOSS_CNT  = loss_cnt_q;
    assign ERR_CNT   = err_cnt_q;
    assign STATE     = state_q;

endmodule
`default_nettype wire

// File: doc/rx_source_ctrl.md
# rx_source_ctrl

Controller that drives the `SIM_EN` select of the receive-path source mux, choosing between the simulated link source and the live DTC transceiver. Source changes are made only on a comma boundary of the active stream, or after a bounded timeout. Each change is followed by a flush hold and a re-alignment qualification before the link is declared up. While the link is up, the block monitors the selected source for lock loss and symbol errors.

## Interface
Parameters:
- `Comma`, 16'hBC3C, boundary word (K28.5 K28.1)
- `KChar`, 2'b11, K flags accompanying `Comma`
- `HOLD_CYC`, 4, flush cycles after a select change (≥1)
- `ALIGN_CYC`, 16, consecutive good cycles required for link-up (≥1)
- `COMMA_TO`, 1024, comma-wait timeout in cycles (≥1, ≤65535)

Ports:
- `RX_CLK`  in  1  receive clock, single clock domain
- `RX_RSTN`  in  1  asynchronous, active-low reset
- `SIM_REQ`  in  1  requested source (1 = sim, 0 = DTC); synchronous to `RX_CLK`
- `ERR_CLR`  in  1  synchronous clear of `ERR_CNT` and `LOSS_CNT`
- `SIM_DATA` / `DTC_DATA`  in  16  stream words
- `SIM_K_CHAR` / `DTC_K_CHAR`  in  2  K flags
- `SIM_CODE_ERR_N` / `DTC_CODE_ERR_N`  in  2  code error, active-low
- `SIM_INVALID` / `DTC_INVALID`  in  2  invalid-K flags
- `SIM_ALIGNED` / `DTC_ALIGNED`  in  1  word aligned
- `SIM_RX_VALID` / `DTC_RX_VALID`  in  1  data valid
- `SIM_EN`  out  1  mux select
- `LINK_UP`  out  1  selected source qualified and passing data
- `SWITCHING`  out  1  change in progress
- `LOCK_LOST`  out  1  one-cycle pulse on loss of the selected source
- `LOSS_CNT`  out  8  lock-loss events, saturating
- `ERR_CNT`  out  16  error cycles while up, saturating
- `STATE`  out  2  ALIGN_WAIT=0, RUN=1, COMMA_WAIT=2, HOLD=3

## Operation
- The selected source ("sel") is the SIM inputs when `SIM_EN`=1, otherwise the DTC inputs.
- "good" means sel ALIGNED=1 and RX_VALID=1.
- "comma" means sel DATA==`Comma` and K_CHAR==`KChar`.
- "err" means CODE_ERR_N≠2'b11 or INVALID≠2'b00.
- ALIGN_WAIT:
  - If `SIM_REQ`≠`SIM_EN`, go to HOLD; the boundary is not needed because the link is down.
  - Otherwise count consecutive good cycles. A non-good cycle resets the count to 0.
  - When the count reaches `ALIGN_CYC`, go to RUN.
- RUN:
  - If not good, go to ALIGN_WAIT, pulse `LOCK_LOST`, and increment `LOSS_CNT`.
  - Otherwise, if `SIM_REQ`≠`SIM_EN`, go to COMMA_WAIT. Lock loss has priority over a request.
  - `ERR_CNT` increments on each err cycle spent in RUN.
- COMMA_WAIT (old source still passed through):
  - If not good, go to HOLD, pulse `LOCK_LOST`, and increment `LOSS_CNT`.
  - Else if `SIM_REQ`==`SIM_EN` (request withdrawn), return to RUN.
  - Else if comma is seen, or the wait counter reaches `COMMA_TO`-1, go to HOLD.
- HOLD:
  - `SIM_EN` toggles on the entering edge.
  - Stay in HOLD for exactly `HOLD_CYC` cycles, then go to ALIGN_WAIT.
  - `SIM_REQ` and the source inputs are ignored in HOLD.
- Counters:
  - The wait/hold/align counter is 16 bits and clears on every state change.
  - `ERR_CNT` saturates at 16'hFFFF; `LOSS_CNT` saturates at 8'hFF.
  - `ERR_CLR` clears both counters and has priority over a same-cycle increment.
- Derived outputs:
  - `LINK_UP`=1 in RUN and COMMA_WAIT.
  - `SWITCHING`=1 in COMMA_WAIT and HOLD.

## Timing
- All outputs are registered.
- The state and its derived outputs update on the edge that samples the triggering condition.
- Reset values:
  - STATE=ALIGN_WAIT (0), `SIM_EN`=0, `LINK_UP`=0, `SWITCHING`=0, `LOCK_LOST`=0.
  - `LOSS_CNT`=0, `ERR_CNT`=0, all internal counters 0.
- Reset asserted mid-switch aborts immediately and returns to DTC selection.
- Link-up latency from entering ALIGN_WAIT, with continuously good input, is `ALIGN_CYC` edges.
- `SIM_EN` changes only on a COMMA_WAIT→HOLD or ALIGN_WAIT→HOLD edge.
- The downstream mux registers its output, so the first word from the new source appears 1 cycle after the `SIM_EN` change. This word lands inside HOLD when `HOLD_CYC`≥1.
- If a comma arrives on the same cycle as the timeout, both lead to HOLD with identical behaviour.
- After HOLD, a still-mismatched request re-enters HOLD without link-up; this is a legal toggle-back.

## Test plan
- **Reset and link-up.** Reset, DTC good from cycle 0, `SIM_REQ`=0 → STATE=1 and `LINK_UP`=1 after 16 edges; `SIM_EN`=0; `LOSS_CNT`=0.
- **Comma-boundary switch.** In RUN, raise `SIM_REQ`; DTC_DATA=16'hBC3C with K=2'b11 three cycles later → `SIM_EN`=1 on that comma's edge and `LINK_UP`=0. HOLD lasts 4 cycles, then 16 good SIM cycles bring `LINK_UP`=1.
- **Comma timeout.** Switch requested with no comma → HOLD entered exactly 1024 cycles after COMMA_WAIT entry.
- **Withdrawn request.** `SIM_REQ` pulses high for 5 cycles with no comma → STATE goes 1→2→1, `SIM_EN` stays 0, `LINK_UP` never drops.
- **Lock loss in RUN.** Drop DTC_ALIGNED for 1 cycle → `LOCK_LOST` is a single pulse, `LOSS_CNT`=1, STATE=0, and re-qualification takes 16 cycles. Then 300 further losses → `LOSS_CNT`=255.
- **Error count and clear.** In RUN, hold DTC_CODE_ERR_N=2'b10 for 10 cycles → `ERR_CNT`=10. Assert `ERR_CLR` together with an err cycle → `ERR_CNT`=0.
